// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: constants and Gray-code helpers shared by the read- and
// write-side pointer handlers of the asynchronous FIFO.
package async_fifo_pkg;

    // Default pointer width: depth 2^(PTR_W-1) plus one wrap bit.
    localparam int PTR_W = 5;

    // Binary to reflected Gray. Narrower pointers are zero-extended by the caller.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray to binary as an XOR prefix from the MSB down.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_n.sv
// gray2bin_n: combinational N-bit Gray-to-binary decode.
// Bit i of the result is the XOR of all Gray bits from the MSB down to i.
module gray2bin_n #(
    parameter int N = 5
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign bin[i] = ^gray[N-1:i];
    end

endmodule

// File: rtl/rptr_handler.sv
// rptr_handler: read-clock-domain pointer logic of the asynchronous FIFO.
// Keeps the binary and Gray read pointers, drives the memory read address and
// a registered empty flag from the synchronized Gray write pointer.
// Optional feature macro ASYNC_FIFO_RLEVEL_EN builds the occupancy estimate
// (rlevel) and almost_empty; without it rlevel is 0 and almost_empty follows empty.
module rptr_handler
    import async_fifo_pkg::*;
#(
    parameter int          n     = PTR_W,
    parameter int unsigned AE_TH = 2
) (
    input  logic         clk,
    input  logic         rresetn,
    input  logic         rinc,
    input  logic [n-1:0] rq2wptr,
    output logic [n-2:0] rdaddr,
    output logic [n-1:0] rptr,
    output logic         empty,
    output logic         almost_empty,
    output logic [n-1:0] rlevel
);

    // A threshold above the FIFO depth can never be reached and is a setup error.
    if (AE_TH > (1 << (n - 1))) begin : g_bad_ae_th
        $error("rptr_handler: AE_TH exceeds FIFO depth");
    end

    logic [n-1:0] rbin;
    logic [n-1:0] rbin_next;
    logic [n-1:0] rgray;
    logic [n-1:0] rgray_next;
    logic         advance;

    // Reads while empty are dropped so the pointer can never pass the writer.
    assign advance    = rinc & ~empty;
    assign rbin_next  = rbin + {{(n-1){1'b0}}, advance};
    assign rgray_next = n'(bin2gray(32'(rbin_next)));
    assign rptr       = rgray;

    // Pointer, address and empty registers; empty compares the full Gray
    // value so the wrap bit separates a full FIFO from an empty one.
    always_ff @(posedge clk or negedge rresetn) begin
        if (!rresetn) begin
            rbin   <= '0;
            rgray  <= '0;
            rdaddr <= '0;
            empty  <= 1'b1;
        end else begin
            rbin   <= rbin_next;
            rgray  <= rgray_next;
            rdaddr <= rbin_next[n-2:0];
            empty  <= (rgray_next == rq2wptr);
        end
    end

`ifdef ASYNC_FIFO_RLEVEL_EN
    localparam logic [n-1:0] AE_TH_N = n'(AE_TH);

    logic [n-1:0] wbin;
    logic [n-1:0] rlevel_next;

    gray2bin_n #(.N(n)) u_wdec (
        .gray (rq2wptr),
        .bin  (wbin)
    );

    // Modulo-2^n difference; the synchronized write pointer lags, so this
    // can only under-report what is really in the FIFO.
    assign rlevel_next = wbin - rbin_next;

    // Level and almost_empty registers, same latency as empty.
    always_ff @(posedge clk or negedge rresetn) begin
        if (!rresetn) begin
            rlevel       <= '0;
            almost_empty <= 1'b1;
        end else begin
            rlevel       <= rlevel_next;
            almost_empty <= (rlevel_next <= AE_TH_N);
        end
    end
`else
    assign rlevel       = '0;
    assign almost_empty = empty;
`endif

endmodule

// File: tb/tb_rptr_handler.sv
// tb_rptr_handler: directed vector table plus randomized traffic checked
// against a counting model of the FIFO (total writes seen vs. total reads).
module tb_rptr_handler;

    localparam int N     = 5;
    localparam int AE    = 2;
    localparam int DEPTH = 16;
`ifdef ASYNC_FIFO_RLEVEL_EN
    localparam bit LVL_EN = 1'b1;
`else
    localparam bit LVL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rresetn;
    logic         rinc;
    logic [N-1:0] rq2wptr;
    logic [N-2:0] rdaddr;
    logic [N-1:0] rptr;
    logic         empty;
    logic         almost_empty;
    logic [N-1:0] rlevel;

    rptr_handler #(.n(N), .AE_TH(AE)) dut (
        .clk          (clk),
        .rresetn      (rresetn),
        .rinc         (rinc),
        .rq2wptr      (rq2wptr),
        .rdaddr       (rdaddr),
        .rptr         (rptr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rlevel       (rlevel)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: how many writes the read side has seen, and how many reads done.
    int wcount;
    int rcount;
    bit m_empty;

    function automatic logic [N-1:0] to_gray(input int v);
        logic [N-1:0] b;
        b = v[N-1:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        int occ;
        occ = wcount - rcount;
        chk({tag, ".rptr"},   int'(rptr),   int'(to_gray(rcount)));
        chk({tag, ".rdaddr"}, int'(rdaddr), rcount % DEPTH);
        chk({tag, ".empty"},  int'(empty),  int'(occ == 0));
        chk({tag, ".rlevel"}, int'(rlevel), LVL_EN ? occ : 0);
        chk({tag, ".ae"},     int'(almost_empty), LVL_EN ? int'(occ <= AE) : int'(occ == 0));
    endtask

    // One read-clock cycle from a negedge to the next negedge.
    task automatic cycle(input bit ri, input bit wi, input string tag);
        logic [N-1:0] prev;
        prev = rptr;
        rinc = ri;
        if (wi && (wcount - rcount) < DEPTH) wcount++;
        rq2wptr = to_gray(wcount);
        @(posedge clk);
        if (ri && !m_empty) rcount++;
        m_empty = (wcount == rcount);
        @(negedge clk);
        chk({tag, ".rptr_1bit"}, int'($countones(rptr ^ prev) <= 1), 1);
        chk_model(tag);
    endtask

    task automatic do_reset();
        rresetn = 1'b0;
        rinc    = 1'b1;
        rq2wptr = '0;
        wcount  = 0;
        rcount  = 0;
        m_empty = 1'b1;
        repeat (2) @(negedge clk);
        chk_model("reset");
        rresetn = 1'b1;
    endtask

    typedef struct {
        bit           ri;
        logic [N-1:0] wg;
        bit           e;
        logic [N-1:0] p;
        logic [N-2:0] a;
        int           lvl;
        bit           ae;
    } vec_t;

    vec_t vt[12];
    int   wraps;
    logic [N-2:0] pa;

    initial begin
        // rinc, rq2wptr -> empty, rptr, rdaddr, rlevel, almost_empty (after the edge)
        vt[0]  = '{1'b1, 5'b00000, 1'b1, 5'b00000, 4'd0, 0, 1'b1}; // read while empty ignored
        vt[1]  = '{1'b0, 5'b00001, 1'b0, 5'b00000, 4'd0, 1, 1'b1}; // first write seen
        vt[2]  = '{1'b1, 5'b00001, 1'b1, 5'b00001, 4'd1, 0, 1'b1}; // last-entry read
        vt[3]  = '{1'b1, 5'b00001, 1'b1, 5'b00001, 4'd1, 0, 1'b1}; // frozen while empty
        vt[4]  = '{1'b0, 5'b00011, 1'b0, 5'b00001, 4'd1, 1, 1'b1};
        vt[5]  = '{1'b0, 5'b00010, 1'b0, 5'b00001, 4'd1, 2, 1'b1}; // at threshold
        vt[6]  = '{1'b0, 5'b00110, 1'b0, 5'b00001, 4'd1, 3, 1'b0}; // above threshold
        vt[7]  = '{1'b1, 5'b00111, 1'b0, 5'b00011, 4'd2, 3, 1'b0}; // read + write
        vt[8]  = '{1'b1, 5'b00111, 1'b0, 5'b00010, 4'd3, 2, 1'b1};
        vt[9]  = '{1'b1, 5'b00111, 1'b0, 5'b00110, 4'd4, 1, 1'b1};
        vt[10] = '{1'b1, 5'b00101, 1'b0, 5'b00111, 4'd5, 1, 1'b1}; // same-edge at level 1
        vt[11] = '{1'b1, 5'b00101, 1'b1, 5'b00101, 4'd6, 0, 1'b1};

        rresetn = 1'b0;
        rinc    = 1'b1;
        rq2wptr = '0;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            rinc    = vt[i].ri;
            rq2wptr = vt[i].wg;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d.empty", i),  int'(empty),  int'(vt[i].e));
            chk($sformatf("vec%0d.rptr", i),   int'(rptr),   int'(vt[i].p));
            chk($sformatf("vec%0d.rdaddr", i), int'(rdaddr), int'(vt[i].a));
            chk($sformatf("vec%0d.rlevel", i), int'(rlevel), LVL_EN ? vt[i].lvl : 0);
            chk($sformatf("vec%0d.ae", i),     int'(almost_empty), LVL_EN ? int'(vt[i].ae) : int'(vt[i].e));
        end

        // Full FIFO: sixteen entries visible at once, then drained.
        do_reset();
        wcount = DEPTH;
        cycle(1'b0, 1'b0, "full");
        chk("full.rlevel16", int'(rlevel), LVL_EN ? 16 : 0);
        chk("full.gray", int'(rq2wptr), int'(5'b11000));
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, "drain");
        chk("drain14.ae", int'(almost_empty), LVL_EN ? 1 : 0);
        chk("drain14.rlevel", int'(rlevel), LVL_EN ? 2 : 0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, "drain");
        chk("drained.empty", int'(empty), 1);
        chk("drained.rptr", int'(rptr), int'(5'b11000));
        chk("drained.rdaddr", int'(rdaddr), 0);

        // Wrap: keep writing ahead of the reader for a full 32-read lap.
        do_reset();
        wraps = 0;
        for (int i = 0; i < 100 && rcount < 32; i++) begin
            pa = rdaddr;
            cycle(1'b1, 1'b1, "wrap");
            if (pa == 4'd15 && rdaddr == 4'd0) wraps++;
        end
        chk("wrap.reads", rcount, 32);
        chk("wrap.rptr", int'(rptr), 0);
        chk("wrap.addr_wraps", wraps, 2);

        // Random traffic with phases biased toward filling or draining.
        for (int i = 0; i < 1500; i++) begin
            int wp;
            wp = ((i / 150) % 2 == 0) ? 3 : 1;
            cycle(1'($urandom_range(0, 3) != 0 ? (i / 150) % 2 : 1),
                  1'($urandom_range(0, 3) < wp), "rand");
        end

        // Asynchronous reset between edges with data in flight.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, "prefill");
        #2 rresetn = 1'b0;
        #1;
        chk("areset.empty",  int'(empty), 1);
        chk("areset.ae",     int'(almost_empty), 1);
        chk("areset.rptr",   int'(rptr), 0);
        chk("areset.rdaddr", int'(rdaddr), 0);
        chk("areset.rlevel", int'(rlevel), 0);
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, "post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rptr_handler.md
# rptr_handler

Read-side pointer handler for the asynchronous FIFO and the counterpart of the write-side handler. Lives entirely in the read clock domain. Keeps the binary and Gray read pointers and generates the memory read address and a registered `empty` flag from the write pointer, which arrives synchronized into the read domain. An optional fill-level estimate and `almost_empty` flag are also provided.

## Interface
- `n`, 5, pointer width in bits; FIFO depth = 2^(n-1); memory address width = n-1.
- `AE_TH`, 2, `almost_empty` threshold in entries; legal range 0..2^(n-1).

- `clk`  in  1  read-domain clock.
- `rresetn`  in  1  reset; one clock, asynchronous, active-low.
- `rinc`  in  1  read request from the consumer.
- `rq2wptr`  in  n  Gray write pointer after the 2-FF synchronizer into `clk`.
- `rdaddr`  out  n-1  binary read address to the dual-port memory.
- `rptr`  out  n  Gray read pointer, sent to the write-domain synchronizer.
- `empty`  out  1  FIFO empty; registered.
- `almost_empty`  out  1  occupancy ≤ `AE_TH`; registered.
- `rlevel`  out  n  read-side occupancy estimate, 0..2^(n-1); registered.

## Operation
- `advance = rinc & ~empty`. Asserting `rinc` while empty is ignored; no pointer moves.
- State registers:
  - `rbin[n-1:0]` binary pointer.
  - `rgray` Gray pointer.
  - `rdaddr`, `empty`, `rlevel`, `almost_empty`.
- Next-state values:
  - `rbin_next = rbin + advance`, modulo 2^n.
  - `rgray_next = rbin_next ^ (rbin_next >> 1)`.
- On each edge:
  - `rbin <= rbin_next`, `rgray <= rgray_next`, `rdaddr <= rbin_next[n-2:0]`.
  - `rptr = rgray`. It changes by at most one bit per edge.
- Empty: `empty <= (rgray_next == rq2wptr)`, a full n-bit compare, MSB included.
- Level:
  - `wbin = gray2bin(rq2wptr)`.
  - `rlevel <= (wbin - rbin_next) mod 2^n`.
  - `almost_empty <= (rlevel_next <= AE_TH)`.
- Wrap-around:
  - `rbin` wraps 2^n-1 → 0.
  - `rdaddr` wraps 2^(n-1)-1 → 0.
  - The Gray MSB toggles every 2^(n-1) reads, which distinguishes full from empty.
- `rq2wptr` is a valid Gray code that steps by at most one code per write.
- `rlevel` is pessimistic: it lags writes by the synchronizer latency and never over-reports.
- Read and write at the same time: a read on the same edge that `rq2wptr` advances leaves `empty` = 0 when the FIFO held 1 entry. Level is unchanged.
- Reset values:
  - `rbin`, `rgray`, `rptr`, `rdaddr`, `rlevel` = 0.
  - `empty` = 1, `almost_empty` = 1.
- Reset mid-operation: asynchronous, and outputs take their reset values immediately. The write domain is reset in the same event; a one-sided reset is not supported.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Read handshake: data at the current `rdaddr` is consumed in any cycle with `advance` = 1. On that edge `rdaddr`/`rptr` step, and `empty` updates on the same edge.
- Last-entry read: `empty` rises on the edge that consumes the entry, so no further advance is possible.
- Write to `empty` deassert: 1 `clk` after `rq2wptr` changes, which is 3 read clocks after the write-domain pointer update.
- `rlevel` and `almost_empty` have the same 1-cycle latency as `empty`.

## Configuration
- `ASYNC_FIFO_RLEVEL_EN`
  - Defined: the `rlevel`/`almost_empty` logic is built, including the gray-to-binary decode and subtractor.
  - Undefined: `rlevel` is tied to 0 and `almost_empty` equals `empty`; the decode and subtractor are not built.
  - `empty`, the pointers and `rdaddr` behave identically either way.

## Structure
- Package `async_fifo_pkg`:
  - `bin2gray` and `gray2bin` functions.
  - Default pointer width constant (5), shared with the write-side handler.
- Sub-module `gray2bin_n`: a parameterized combinational XOR-prefix decode of `rq2wptr`. The write side reuses it when its level option is added.

## Test plan
- Reset: hold `rresetn`=0 with `rinc`=1 → `empty`=1, `almost_empty`=1, `rptr`=00000, `rdaddr`=0000, `rlevel`=0; pointers stay frozen after release while empty.
- Single entry: `rq2wptr` 00000→00001, `rinc`=0 → next edge `empty`=0, `rlevel`=1. One `rinc` pulse → `rptr`=00001, `rdaddr`=1, `empty`=1 on that edge.
- Full FIFO: `rq2wptr`=11000 (binary 16) with `rbin`=0 → `rlevel`=16, `almost_empty`=0. After 14 reads → `rlevel`=2, `almost_empty`=1. After 16 reads → `empty`=1, `rptr`=11000, `rdaddr`=0.
- Wrap: 32 reads with writes kept ahead → `rptr` returns to 00000 and `rdaddr` passes 15→0 twice. Check `rptr` for single-bit changes throughout.
- Same-edge read and write at level 1: `rinc`=1 while `rq2wptr` advances → `empty` stays 0, `rlevel` stays 1.
- Mid-stream async reset between edges → all outputs take reset values before the next `clk` edge. Rebuild with `ASYNC_FIFO_RLEVEL_EN` undefined → `rlevel`≡0 and `almost_empty`≡`empty`.
